// File: rtl/spi_slave_adc.sv
// rtl/spi_slave_adc.sv - SPI responder: oversampled SCK/CSbar/MOSI, MSB-first rx word, preloaded tx reply
module spi_slave_adc #(
  parameter int outBits = 16
) (
  input  logic               SYS_CLK,
  input  logic               RST,
  input  logic               SCK,
  input  logic               CSbar,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [outBits-1:0] DATA_TX,
  output logic [outBits-1:0] DATA_RX,
  output logic               RX_VALID,
  output logic               FRAME_ERR,
  output logic               BUSY
);

  localparam int CW = $clog2(outBits + 1);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE, DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_sck_sync;
  logic [2:0]         r_cs_sync;
  logic [1:0]         r_mosi_sync;
  logic [2:0]         r_fill;
  logic [outBits-1:0] r_tx;
  logic [outBits-1:0] r_rx;
  logic [CW-1:0]      r_cnt;
  logic               r_miso;
  logic [outBits-1:0] r_data_rx;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_busy;

  logic               w_cs_fall;
  logic               w_cs_rise;
  logic               w_sck_rise;
  logic               w_sck_fall;
  logic               w_mosi;
  logic [outBits-1:0] w_rx_next;
  logic [outBits-1:0] w_tx_next;
  logic [CW-1:0]      w_cnt_next;

  // MOSI stage 2 lines up with stage 2 of SCK/CSbar, where the edge events are taken.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_sck_sync  <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
      r_fill      <= 3'b000;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], SCK};
      r_cs_sync   <= {r_cs_sync[1:0], CSbar};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      r_fill      <= {r_fill[1:0], 1'b1};
    end
  end

  assign w_cs_fall  = ~r_cs_sync[1] &  r_cs_sync[2];
  assign w_cs_rise  =  r_cs_sync[1] & ~r_cs_sync[2];
  assign w_sck_rise =  r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] &  r_sck_sync[2];
  assign w_mosi     = r_mosi_sync[1];
  assign w_rx_next  = {r_rx[outBits-2:0], w_mosi};
  assign w_tx_next  = {r_tx[outBits-2:0], 1'b0};
  assign w_cnt_next = r_cnt + CW'(1);

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_state     <= WAIT_HIGH;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cnt       <= '0;
      r_miso      <= 1'b0;
      r_data_rx   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        WAIT_HIGH: begin
          r_miso <= 1'b0;
          r_busy <= 1'b0;
          // Only trust CSbar once the synchronizer holds real samples, not its reset preset.
          if (r_fill[2] && r_cs_sync[1] && r_cs_sync[2]) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_cs_fall) begin
            r_tx    <= DATA_TX;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_miso  <= DATA_TX[outBits-1];
            r_busy  <= 1'b1;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (w_sck_fall) begin
            r_rx  <= w_rx_next;
            r_cnt <= w_cnt_next;
            if (w_cnt_next == CW'(outBits)) begin
              r_data_rx  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_state    <= DONE;
            end
          end else if (w_sck_rise) begin
            r_tx   <= w_tx_next;
            r_miso <= w_tx_next[outBits-1];
          end
        end
        DONE: begin
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= WAIT_HIGH;
      endcase
    end
  end

  assign MISO      = r_miso;
  assign DATA_RX   = r_data_rx;
  assign RX_VALID  = r_rx_valid;
  assign FRAME_ERR = r_frame_err;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_spi_slave_adc.sv
// tb/tb_spi_slave_adc.sv - self-checking bench for spi_slave_adc acting as the SPI master
module tb_spi_slave_adc;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SCK = 1'b0;
  logic        CSbar = 1'b1;
  logic        MOSI = 1'b0;
  logic [15:0] DATA_TX = 16'h0000;
  logic        MISO;
  logic [15:0] DATA_RX;
  logic        RX_VALID;
  logic        FRAME_ERR;
  logic        BUSY;

  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [15:0] rx_model = 16'h0000;

  spi_slave_adc #(.outBits(16)) dut (
    .SYS_CLK  (SYS_CLK),
    .RST      (RST),
    .SCK      (SCK),
    .CSbar    (CSbar),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .DATA_TX  (DATA_TX),
    .DATA_RX  (DATA_RX),
    .RX_VALID (RX_VALID),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  always @(negedge SYS_CLK) begin
    if (RX_VALID === 1'b1) valid_cnt++;
    if (FRAME_ERR === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [15:0] mosi;
    logic [15:0] tx;
    int          n;
    bit          chg;
    bit          exp_valid;
    bit          exp_err;
    logic [15:0] exp_rx;
  } vec_t;

  // Reply seen by the master: one bit per SCK rise, tx MSB first, zeros once the word is spent.
  function automatic logic [31:0] model_reply(input logic [15:0] tx, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], (i < 16) ? tx[15-i] : 1'b0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sck_cycles(input logic [15:0] word, input int n, input bit chg,
                            output logic [31:0] reply);
    reply = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge SYS_CLK);
      SCK   = 1'b1;
      reply = {reply[30:0], MISO};
      MOSI  = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
      if (chg && i == 3) DATA_TX = 16'($urandom);
      repeat (2) @(negedge SYS_CLK);
      SCK = 1'b0;
      @(negedge SYS_CLK);
    end
    @(negedge SYS_CLK);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] mosi, input logic [15:0] tx,
                           input int n, input bit chg, input bit ev, input bit ee,
                           input logic [15:0] erx);
    int v0, e0;
    logic [31:0] r;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge SYS_CLK);
    DATA_TX = tx;
    CSbar   = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    sck_cycles(mosi, n, chg, r);
    chk({tag, "_busy_mid"}, 32'(BUSY), 32'd1);
    CSbar = 1'b1;
    repeat (6) @(negedge SYS_CLK);
    chk({tag, "_rx_valid"}, 32'(valid_cnt - v0), 32'(ev));
    chk({tag, "_frame_err"}, 32'(err_cnt - e0), 32'(ee));
    chk({tag, "_data_rx"}, 32'(DATA_RX), 32'(erx));
    chk({tag, "_miso"}, r, model_reply(tx, n));
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    vec_t        tbl[6];
    logic [31:0] r;
    logic        miso_or, busy_or;
    int          v0, e0;

    tbl[0] = '{16'hA5C3, 16'h1234, 16, 1'b0, 1'b1, 1'b0, 16'hA5C3};
    tbl[1] = '{16'hFFFF, 16'h0F0F, 16, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    tbl[2] = '{16'h0001, 16'h8001, 16, 1'b1, 1'b1, 1'b0, 16'h0001};
    tbl[3] = '{16'h5A5A, 16'hCAFE,  9, 1'b0, 1'b0, 1'b1, 16'h0001};
    tbl[4] = '{16'h00FF, 16'h7E81, 16, 1'b0, 1'b1, 1'b0, 16'h00FF};
    tbl[5] = '{16'h3C3C, 16'hFFFF, 20, 1'b0, 1'b1, 1'b0, 16'h3C3C};

    repeat (3) @(negedge SYS_CLK);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_data_rx", 32'(DATA_RX), 32'd0);
    chk("rst_rx_valid", 32'(RX_VALID), 32'd0);
    chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    repeat (6) @(negedge SYS_CLK);

    // SCK activity with CSbar high must be ignored.
    v0 = valid_cnt;
    e0 = err_cnt;
    miso_or = 1'b0;
    busy_or = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge SYS_CLK);
      SCK  = ~SCK;
      MOSI = 1'($urandom_range(0, 1));
      @(negedge SYS_CLK);
      miso_or = miso_or | MISO;
      busy_or = busy_or | BUSY;
    end
    SCK = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    chk("idle_miso", 32'(miso_or), 32'd0);
    chk("idle_busy", 32'(busy_or), 32'd0);
    chk("idle_pulses", 32'(valid_cnt - v0 + err_cnt - e0), 32'd0);

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("tbl%0d", k), tbl[k].mosi, tbl[k].tx, tbl[k].n, tbl[k].chg,
                tbl[k].exp_valid, tbl[k].exp_err, tbl[k].exp_rx);
    end
    rx_model = 16'h3C3C;

    // Reset in the middle of a frame, released while CSbar is still low.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge SYS_CLK);
    DATA_TX = 16'h1111;
    CSbar   = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    sck_cycles(16'hA5A5, 8, 1'b0, r);
    RST = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    chk("midrst_miso", 32'(MISO), 32'd0);
    chk("midrst_data_rx", 32'(DATA_RX), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    sck_cycles(16'hFFFF, 8, 1'b0, r);
    chk("midrst_wait_miso", r, 32'd0);
    chk("midrst_wait_busy", 32'(BUSY), 32'd0);
    CSbar = 1'b1;
    repeat (6) @(negedge SYS_CLK);
    chk("midrst_pulses", 32'(valid_cnt - v0 + err_cnt - e0), 32'd0);
    rx_model = 16'h0000;
    run_frame("beef", 16'hBEEF, 16'h4321, 16, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    rx_model = 16'hBEEF;

    for (int k = 0; k < 20; k++) begin
      logic [15:0] m, t;
      int          n;
      bit          full;
      m = 16'($urandom);
      t = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(16, 22));
      full = (n >= 16);
      if (full) rx_model = m;
      run_frame($sformatf("rnd%0d", k), m, t, n, 1'($urandom_range(0, 1)), full, !full, rx_model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
